game_countdown_timer: RTL

//  Per-turn countdown timer for the two-player sequence matching game.

---
 rtl/game_countdown_timer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/game_countdown_timer.sv
// -----------------------------------------------------------------------------
// game_countdown_timer
//   Per-turn countdown timer for the two-player sequence matching game.
//   Counts whole seconds down in BCD. The two digits feed the tens/ones
//   seven-segment decoders directly. Entering 00 ends the turn: a one-cycle
//   expired pulse plus a timeout level that the game controller can watch.
//
// Parameters
//   TICK_CYCLES  clk cycles per second (small value for simulation)
//   START_SECS   reset value in seconds, 0..99
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   load       in   load load_tens/load_ones, enter IDLE (highest priority)
//   load_tens  in   BCD tens digit to load (values >9 clamp to 9)
//   load_ones  in   BCD ones digit to load (values >9 clamp to 9)
//   start      in   IDLE->RUN (count must be nonzero), PAUSE->RUN
//   pause      in   RUN->PAUSE
//   tens       out  BCD tens digit
//   ones       out  BCD ones digit
//   running    out  high while in RUN
//   expired    out  one-cycle pulse on the edge the count becomes 00
//   timeout    out  high while in DONE
//   All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module game_countdown_timer #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int START_SECS  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    RST_TENS   = 4'((START_SECS / 10) % 10);
    localparam logic [3:0]    RST_ONES   = 4'(START_SECS % 10);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          timeout_q, timeout_d;

    logic count_zero;
    logic last_sec;
    logic tick;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    // The next decrement lands on 00 only from 01.
    assign last_sec   = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign tick       = (presc_q == PRESC_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !count_zero) state_d = RUN;
                end
                RUN: begin
                    // start is a no-op here, so pause still takes effect.
                    if (pause)                 state_d = PAUSE;
                    else if (tick && last_sec) state_d = DONE;
                end
                PAUSE: begin
                    if (start) state_d = RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------- output comb
    // Flag outputs are registered versions of the decoded next state so that
    // expired/timeout/running change on the same edge as the digits.
    always_comb begin
        running_d = (state_d == RUN);
        timeout_d = (state_d == DONE);
        expired_d = (state_q == RUN) && (state_d == DONE);
    end

    // ---------------------------------------------------------- datapath comb
    always_comb begin
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (load) begin
            // Load beats a coincident tick: no decrement is applied.
            tens_d  = clamp_bcd(load_tens);
            ones_d  = clamp_bcd(load_ones);
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !count_zero) presc_d = '0;
                end
                RUN: begin
                    // Pausing freezes the prescaler mid-second; resume from
                    // PAUSE keeps it, so the partial second is not lost.
                    if (!pause) begin
                        if (tick) begin
                            presc_d = '0;
                            if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // PAUSE and DONE hold everything.
                end
            endcase
        end
    end

    // ------------------------------------------------------------ datapath regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            tens_q    <= RST_TENS;
            ones_q    <= RST_ONES;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= running_d;
            expired_q <= expired_d;
            timeout_q <= timeout_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign expired = expired_q;
    assign timeout = timeout_q;

endmodule
